// File: rtl/v_pkg.sv
// Shared types for the list manager and its update-bus ingress.
package v_pkg;

    typedef logic [7:0]  id_t;
    typedef logic [1:0]  cmd_t;
    typedef logic [15:0] key_t;
    typedef logic [15:0] size_t;

    typedef struct packed {
        id_t   prod_id;
        cmd_t  cmd;
        key_t  key;
        size_t size;
    } upd_t;

endpackage

// File: rtl/v_upd_fifo.sv
// Update FIFO: storage, wrapping pointers, level and full/empty flags.
module v_upd_fifo
    import v_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        i_push,
    input  logic        i_pop,
    input  logic        i_flush,
    input  upd_t        i_wdata,
    output upd_t        o_rdata,
    output logic [AW:0] o_level,
    output logic        o_empty,
    output logic        o_full
);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   level_q, level_d;
    upd_t          mem_q [DEPTH];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (i_flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            wptr_d  = wptr_q + AW'(i_push);
            rptr_d  = rptr_q + AW'(i_pop);
            level_d = level_q + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage is not reset; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) mem_q[wptr_q] <= i_wdata;
    end

    assign o_rdata = mem_q[rptr_q];
    assign o_level = level_q;
    assign o_empty = (level_q == '0);
    assign o_full  = (level_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/v_upd_ingress.sv
// Update-bus ingress: buffers producer updates and issues one at a time to v
// only while v is idle.
module v_upd_ingress
    import v_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        i_in_vld,
    input  id_t         i_in_prod_id,
    input  cmd_t        i_in_cmd,
    input  key_t        i_in_key,
    input  size_t       i_in_size,
    output logic        o_in_rdy,
    input  logic        i_flush,
    output logic        o_upd_vld_r,
    output id_t         o_upd_prod_id_r,
    output cmd_t        o_upd_cmd_r,
    output key_t        o_upd_key_r,
    output size_t       o_upd_size_r,
    input  logic        i_busy_r,
    output logic [AW:0] o_level_r,
    output logic        o_empty_r,
    output logic        o_full_r,
    output logic [31:0] o_issued_cnt_r
);

    upd_t        in_upd, head_upd;
    upd_t        upd_q, upd_d;
    logic        upd_vld_q, upd_vld_d;
    logic [31:0] cnt_q, cnt_d;
    logic        push, issue;

    assign in_upd   = '{prod_id: i_in_prod_id, cmd: i_in_cmd, key: i_in_key, size: i_in_size};
    assign o_in_rdy = !o_full_r && !i_flush;
    assign push     = i_in_vld && o_in_rdy;
    // Blocking on our own valid forces an idle cycle so v's busy catches up.
    assign issue    = !o_empty_r && !i_busy_r && !upd_vld_q && !i_flush;

    v_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .arst_n  (arst_n),
        .i_push  (push),
        .i_pop   (issue),
        .i_flush (i_flush),
        .i_wdata (in_upd),
        .o_rdata (head_upd),
        .o_level (o_level_r),
        .o_empty (o_empty_r),
        .o_full  (o_full_r)
    );

    always_comb begin
        upd_vld_d = issue;
        upd_d     = issue ? head_upd : upd_q;
        cnt_d     = cnt_q + 32'(issue);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            upd_vld_q <= 1'b0;
            upd_q     <= '0;
            cnt_q     <= '0;
        end else begin
            upd_vld_q <= upd_vld_d;
            upd_q     <= upd_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_upd_vld_r     = upd_vld_q;
    assign o_upd_prod_id_r = upd_q.prod_id;
    assign o_upd_cmd_r     = upd_q.cmd;
    assign o_upd_key_r     = upd_q.key;
    assign o_upd_size_r    = upd_q.size;
    assign o_issued_cnt_r  = cnt_q;

endmodule

// File: doc/v_upd_ingress.md
# v_upd_ingress

Update-bus ingress stage sitting directly upstream of the list manager `v`. It buffers producer updates (prod_id, cmd, key, size) in a DEPTH-entry FIFO, applies valid/ready backpressure to the source, and issues at most one update at a time onto `v`'s update bus. It only issues when `v` reports not-busy, so no update is ever presented while the list manager is occupied.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `clk`  in  1  clock.
- `arst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `i_in_vld`  in  1  source update valid.
- `i_in_prod_id`  in  `v_pkg::id_t`  source product id.
- `i_in_cmd`  in  `v_pkg::cmd_t`  source command (opaque, passed through).
- `i_in_key`  in  `v_pkg::key_t`  source key.
- `i_in_size`  in  `v_pkg::size_t`  source size.
- `o_in_rdy`  out  1  accept; transfer on `i_in_vld & o_in_rdy`.
- `i_flush`  in  1  synchronous discard of all queued entries.
- `o_upd_vld_r`  out  1  drives `v` `i_upd_vld`.
- `o_upd_prod_id_r`, `o_upd_cmd_r`, `o_upd_key_r`, `o_upd_size_r`  out  pkg types  drive `v` `i_upd_*`.
- `i_busy_r`  in  1  from `v` `o_busy_r`.
- `o_level_r`  out  `$clog2(DEPTH)+1`  entries queued.
- `o_empty_r`, `o_full_r`  out  1  level==0 / level==DEPTH.
- `o_issued_cnt_r`  out  32  updates issued since reset, wraps.

## Operation
- FIFO: write pointer, read pointer, level; pointers `$clog2(DEPTH)` bits, wrap naturally at DEPTH.
- `o_in_rdy = !o_full_r & !i_flush` (combinational from registered state only; no full-bypass).
- Issue condition at an edge: `!o_empty_r & !i_busy_r & !o_upd_vld_r & !i_flush`. On issue: head entry registered onto `o_upd_*_r`, `o_upd_vld_r`=1 for exactly one cycle, read pointer advances, `o_issued_cnt_r` increments.
- The mandatory idle cycle after each issue lets `v`'s registered `o_busy_r` reflect the issued update before the next decision.
- Push and pop in the same edge: level unchanged, both pointers advance.
- Flush: pointers and level to 0 at that edge, no push, no issue; an `o_upd_vld_r` already high is unaffected.
- `o_upd_*` data fields hold their last value when `o_upd_vld_r`=0.
- Strict FIFO order; no coalescing, no reordering, no dropping except by flush.

## Timing
- Reset values: `o_upd_vld_r`=0, `o_upd_*` data=0, `o_level_r`=0, `o_empty_r`=1, `o_full_r`=0, `o_issued_cnt_r`=0, `o_in_rdy`=1 (when `i_flush`=0).
- Latency: update accepted at edge t into an empty FIFO with `i_busy_r`=0 appears on `o_upd_vld_r` after edge t+1.
- Throughput: max one issue per two cycles.
- `i_busy_r` high stalls issue indefinitely; the FIFO continues accepting until full.
- Reset asserted mid-operation: all state cleared immediately; queued entries lost.

## Structure
- No new `v_pkg` typedefs needed; reuse `id_t`, `cmd_t`, `key_t`, `size_t`. Add to `v_pkg` a packed `upd_t` struct {prod_id, cmd, key, size} used as the FIFO word.
- One sub-module: `v_upd_fifo` (storage, pointers, level, full/empty). Issue control, counter and output registers live in the top.

## Test plan
- Single update (prod_id=3, key=0x10, size=5), busy=0 -> `o_upd_vld_r` high exactly one cycle, 2 cycles after accept, fields match; `o_issued_cnt_r`=1.
- Burst of 8 back-to-back with DEPTH=8, busy held high -> `o_full_r`=1 after 8th, `o_in_rdy`=0, 9th held by source; release busy -> 8 issues in order, spaced 2 cycles apart, then 9th.
- Busy toggles high the cycle after each issue for 3 cycles -> next issue only after busy falls; no issue while busy=1.
- Flush with level=5 and `i_in_vld`=1 same cycle -> level=0, input not accepted, no issue that edge; next update issues normally.
- Simultaneous push/pop at level=4 -> level stays 4; pointer wrap past DEPTH-1 preserves order across 20 updates.
- `arst_n` asserted with level=3 and `o_upd_vld_r`=1 -> all outputs at reset values immediately, no issue after release until new input.
